// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and register-file writeback bundle for alu_op_sequencer.
// master = CPU/ALU/regfile side, slave = the sequencer.
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_rd;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_res;
    logic [15:0] alu_r15;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd, alu_res, alu_r15,
        input  req_ready, alu_ctrl, alu_a, alu_b, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd, alu_res, alu_r15,
        output req_ready, alu_ctrl, alu_a, alu_b, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time and writes back rd, then R15 for MUL/DIV.
// Optional divide-by-zero trap: define ALU_SEQ_DIV0_TRAP_EN.
//
// state | meaning
// IDLE  | ready for a request, ALU operands driven 0
// EXEC  | operands held on the ALU while the latency counter runs down
// WB_LO | write res_lo to rd (or report an illegal opcode)
// WB_HI | write res_hi to R15 (MUL/DIV only)
module alu_op_sequencer #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus,
    output logic               stall,
    output logic               done,
    output logic               err_op,
    output logic               err_div0
);

    typedef enum logic [1:0] {IDLE, EXEC, WB_LO, WB_HI} state_t;

    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_LAST = 4'd5;
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] CNT_MUL = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] CNT_DIV = CW'(DIV_LAT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [15:0]   a_q, a_d;
    logic [15:0]   b_q, b_d;
    logic [3:0]    rd_q, rd_d;
    logic          ill_q, ill_d;
    logic [15:0]   res_hi_q, res_hi_d;

    logic [3:0]    alu_ctrl_q, alu_ctrl_d;
    logic [15:0]   alu_a_q, alu_a_d;
    logic [15:0]   alu_b_q, alu_b_d;
    logic          wb_en_q, wb_en_d;
    logic [3:0]    wb_addr_q, wb_addr_d;
    logic [15:0]   wb_data_q, wb_data_d;
    logic          done_q, done_d;
    logic          err_op_q, err_op_d;

    logic accept;
    logic div0_hit;
    logic op_wide;

    assign accept  = (state_q == IDLE) && bus.req_valid;
    assign op_wide = (op_q == OP_MUL) || (op_q == OP_DIV);

`ifdef ALU_SEQ_DIV0_TRAP_EN
    logic div0_q;

    assign div0_hit = (bus.req_op == OP_DIV) && (bus.req_b == 16'h0000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div0_q <= 1'b0;
        end else begin
            div0_q <= accept && div0_hit;
        end
    end

    assign err_div0 = div0_q;
`else
    assign div0_hit = 1'b0;
    assign err_div0 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            ill_q      <= 1'b0;
            res_hi_q   <= '0;
            alu_ctrl_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            done_q     <= 1'b0;
            err_op_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_q       <= rd_d;
            ill_q      <= ill_d;
            res_hi_q   <= res_hi_d;
            alu_ctrl_q <= alu_ctrl_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            done_q     <= done_d;
            err_op_q   <= err_op_d;
        end
    end

    // Outputs are registered, so each branch computes what the next cycle shows.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rd_d       = rd_q;
        ill_d      = ill_q;
        res_hi_d   = res_hi_q;
        alu_ctrl_d = '0;
        alu_a_d    = '0;
        alu_b_d    = '0;
        wb_en_d    = 1'b0;
        wb_addr_d  = '0;
        wb_data_d  = '0;
        done_d     = 1'b0;
        err_op_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = bus.req_op;
                    a_d   = bus.req_a;
                    b_d   = bus.req_b;
                    rd_d  = bus.req_rd;
                    ill_d = 1'b0;
                    if (bus.req_op > OP_LAST) begin
                        // Illegal op borrows WB_LO for its single stalled cycle, no write.
                        ill_d    = 1'b1;
                        err_op_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = WB_LO;
                    end else if (div0_hit) begin
                        res_hi_d  = bus.req_a;
                        wb_en_d   = 1'b1;
                        wb_addr_d = bus.req_rd;
                        wb_data_d = 16'hFFFF;
                        state_d   = WB_LO;
                    end else begin
                        alu_ctrl_d = bus.req_op;
                        alu_a_d    = bus.req_a;
                        alu_b_d    = bus.req_b;
                        if (bus.req_op == OP_MUL) begin
                            cnt_d = CNT_MUL;
                        end else if (bus.req_op == OP_DIV) begin
                            cnt_d = CNT_DIV;
                        end else begin
                            cnt_d = '0;
                        end
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    res_hi_d  = bus.alu_r15;
                    wb_en_d   = 1'b1;
                    wb_addr_d = rd_q;
                    wb_data_d = bus.alu_res;
                    done_d    = !op_wide;
                    state_d   = WB_LO;
                end else begin
                    alu_ctrl_d = op_q;
                    alu_a_d    = a_q;
                    alu_b_d    = b_q;
                    cnt_d      = cnt_q - CW'(1);
                end
            end
            WB_LO: begin
                if (ill_q || !op_wide) begin
                    state_d = IDLE;
                end else begin
                    wb_en_d   = 1'b1;
                    wb_addr_d = 4'd15;
                    wb_data_d = res_hi_q;
                    done_d    = 1'b1;
                    state_d   = WB_HI;
                end
            end
            WB_HI: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign stall         = (state_q != IDLE);
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_data   = wb_data_q;
    assign done          = done_q;
    assign err_op        = err_op_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: per-cycle timeline model plus a behavioural ALU.
// Honours ALU_SEQ_DIV0_TRAP_EN when the same macro is given to the build.
module tb_alu_op_sequencer;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    typedef struct {
        logic        stall;
        logic        wb_en;
        logic [3:0]  wb_addr;
        logic [15:0] wb_data;
        logic        done;
        logic        err_op;
        logic        err_div0;
        logic [3:0]  ctrl;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic clk;
    logic rst_n;
    logic stall, done, err_op, err_div0;
    int   n_cmp;
    int   n_bad;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .stall    (stall),
        .done     (done),
        .err_op   (err_op),
        .err_div0 (err_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {r15, res}. Non-MUL/DIV ops put a marker on r15 that must never be written.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa;
        int sb;
        int p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd0: return {16'hA5A5, 16'(sa + sb)};
            4'd1: return {16'hA5A5, 16'(sa - sb)};
            4'd2: begin
                p = sa * sb;
                return 32'(p);
            end
            4'd3: begin
                if (sb == 0) return {16'hBEEF, 16'hDEAD};
                return {16'(sa % sb), 16'(sa / sb)};
            end
            4'd4: return {16'hA5A5, a & b};
            4'd5: return {16'hA5A5, a | b};
            default: return 32'h0;
        endcase
    endfunction

    always_comb {bus.alu_r15, bus.alu_res} = alu_model(bus.alu_ctrl, bus.alu_a, bus.alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e = '{default: '0};
        e.stall = 1'b1;
        return e;
    endfunction

    // Cycle-by-cycle expectations for the cycles after the accept edge.
    task automatic build(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] rd, output exp_t tl[$]);
        exp_t e;
        logic [31:0] r;
        int lat;
        bit wide;
        tl.delete();
        wide = (op == 4'd2) || (op == 4'd3);
        if (op > 4'd5) begin
            e = blank(); e.done = 1'b1; e.err_op = 1'b1;
            tl.push_back(e);
            return;
        end
`ifdef ALU_SEQ_DIV0_TRAP_EN
        if (op == 4'd3 && b == 16'h0) begin
            e = blank(); e.wb_en = 1'b1; e.wb_addr = rd; e.wb_data = 16'hFFFF; e.err_div0 = 1'b1;
            tl.push_back(e);
            e = blank(); e.wb_en = 1'b1; e.wb_addr = 4'd15; e.wb_data = a; e.done = 1'b1;
            tl.push_back(e);
            return;
        end
`endif
        lat = (op == 4'd2) ? MUL_LAT : (op == 4'd3) ? DIV_LAT : 1;
        r = alu_model(op, a, b);
        for (int k = 0; k < lat; k++) begin
            e = blank(); e.ctrl = op; e.a = a; e.b = b;
            tl.push_back(e);
        end
        e = blank(); e.wb_en = 1'b1; e.wb_addr = rd; e.wb_data = r[15:0]; e.done = !wide;
        tl.push_back(e);
        if (wide) begin
            e = blank(); e.wb_en = 1'b1; e.wb_addr = 4'd15; e.wb_data = r[31:16]; e.done = 1'b1;
            tl.push_back(e);
        end
    endtask

    // Called just after a posedge with the DUT idle; returns just after a posedge with it idle again.
    task automatic do_op(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] rd, input bit hold);
        exp_t tl[$];
        build(op, a, b, rd, tl);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
        @(negedge clk);
        chk({nm, ".ready"}, 32'(bus.req_ready), 32'd1);
        chk({nm, ".stall0"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        if (hold) begin
            bus.req_op = 4'($urandom);
            bus.req_a  = 16'($urandom);
            bus.req_b  = 16'($urandom);
            bus.req_rd = 4'($urandom);
        end else begin
            bus.req_valid = 1'b0;
        end
        foreach (tl[k]) begin
            @(negedge clk);
            chk($sformatf("%s.c%0d.stall", nm, k + 1), 32'(stall), 32'(tl[k].stall));
            chk($sformatf("%s.c%0d.ready", nm, k + 1), 32'(bus.req_ready), 32'd0);
            chk($sformatf("%s.c%0d.wb_en", nm, k + 1), 32'(bus.wb_en), 32'(tl[k].wb_en));
            if (tl[k].wb_en) begin
                chk($sformatf("%s.c%0d.wb_addr", nm, k + 1), 32'(bus.wb_addr), 32'(tl[k].wb_addr));
                chk($sformatf("%s.c%0d.wb_data", nm, k + 1), 32'(bus.wb_data), 32'(tl[k].wb_data));
            end
            chk($sformatf("%s.c%0d.done", nm, k + 1), 32'(done), 32'(tl[k].done));
            chk($sformatf("%s.c%0d.err_op", nm, k + 1), 32'(err_op), 32'(tl[k].err_op));
            chk($sformatf("%s.c%0d.err_div0", nm, k + 1), 32'(err_div0), 32'(tl[k].err_div0));
            chk($sformatf("%s.c%0d.alu_ctrl", nm, k + 1), 32'(bus.alu_ctrl), 32'(tl[k].ctrl));
            chk($sformatf("%s.c%0d.alu_a", nm, k + 1), 32'(bus.alu_a), 32'(tl[k].a));
            chk($sformatf("%s.c%0d.alu_b", nm, k + 1), 32'(bus.alu_b), 32'(tl[k].b));
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_quiet(input string nm);
        @(negedge clk);
        chk({nm, ".ready"}, 32'(bus.req_ready), 32'd1);
        chk({nm, ".stall"}, 32'(stall), 32'd0);
        chk({nm, ".wb_en"}, 32'(bus.wb_en), 32'd0);
        chk({nm, ".wb_addr"}, 32'(bus.wb_addr), 32'd0);
        chk({nm, ".wb_data"}, 32'(bus.wb_data), 32'd0);
        chk({nm, ".done"}, 32'(done), 32'd0);
        chk({nm, ".err_op"}, 32'(err_op), 32'd0);
        chk({nm, ".err_div0"}, 32'(err_div0), 32'd0);
        chk({nm, ".alu"}, {12'h0, bus.alu_ctrl, bus.alu_a}, 32'd0);
        chk({nm, ".alu_b"}, 32'(bus.alu_b), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] a, b;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_a  = '0;
        bus.req_b  = '0;
        bus.req_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1'b1;
        chk_quiet("post_reset");

        do_op("add",    4'd0, 16'd5,    16'hFFFD, 4'd2,  1'b0);
        do_op("mul",    4'd2, 16'd300,  16'd300,  4'd4,  1'b0);
        do_op("div",    4'd3, 16'hFFF9, 16'd2,    4'd1,  1'b0);
        do_op("illegal", 4'd9, 16'h1111, 16'h2222, 4'd7, 1'b0);
        chk_quiet("after_illegal");
        do_op("div0",   4'd3, 16'h1234, 16'h0000, 4'd6,  1'b0);
        do_op("mul_r15", 4'd2, 16'h8000, 16'h7FFF, 4'd15, 1'b0);
        do_op("sub",    4'd1, 16'h8000, 16'd1,    4'd3,  1'b0);
        do_op("and",    4'd4, 16'hF0F0, 16'h3C3C, 4'd8,  1'b0);
        do_op("or",     4'd5, 16'hF0F0, 16'h0F01, 4'd9,  1'b0);
        do_op("divneg", 4'd3, 16'h8000, 16'hFFFF, 4'd0,  1'b0);

        // Back-to-back with req_valid held high and garbage while busy.
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            do_op($sformatf("rnd%0d", i), op, a, b, 4'($urandom_range(0, 15)), 1'b1);
        end
        bus.req_valid = 1'b0;
        chk_quiet("idle");

        // Reset in the last EXEC cycle of a MUL must drop the pending writebacks.
        bus.req_valid = 1'b1;
        bus.req_op = 4'd2;
        bus.req_a  = 16'd123;
        bus.req_b  = 16'd456;
        bus.req_rd = 4'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid.exec_ctrl", 32'(bus.alu_ctrl), 32'd2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) chk_quiet($sformatf("rst_mid%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequences the shared 16-bit signed ALU for the CPU datapath.
- Accepts one operation request at a time and holds the operands stable for the op's latency (1 cycle; multi-cycle for MUL/DIV).
- Captures the result plus the R15 half (product high word or remainder) and issues register-file writebacks through a single write port: rd first, then R15.
- Drives the pipeline stall while busy.

Parameters:
- MUL_LAT, 2, EXEC cycles held for multiply (>=1).
- DIV_LAT, 4, EXEC cycles held for divide/modulo (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept; high only in IDLE
- req_op  input  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR; 6-15 illegal
- req_a  input  16  operand A (signed)
- req_b  input  16  operand B (signed)
- req_rd  input  4  destination register
- alu_ctrl  output  4  opcode to ALU
- alu_a  output  16  operand A to ALU
- alu_b  output  16  operand B to ALU
- alu_res  input  16  ALU primary result
- alu_r15  input  16  ALU high product / remainder
- wb_en  output  1  register-file write enable
- wb_addr  output  4  write address
- wb_data  output  16  write data
- stall  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse at operation completion
- err_op  output  1  one-cycle pulse on illegal opcode
- err_div0  output  1  one-cycle pulse on DIV with b==0 (only with the optional feature compiled in)

Behaviour:
- Reset (rst_n low at posedge): state=IDLE; all latches cleared.
  - Reset outputs: alu_ctrl=0, alu_a=0, alu_b=0, wb_en=0, wb_addr=0, wb_data=0, done=0, err_op=0, err_div0=0, stall=0.
  - req_ready is 1 the cycle after reset releases.
  - Reset mid-operation aborts without any writeback.
- States: IDLE, EXEC, WB_LO, WB_HI.
- IDLE:
  - req_ready=1; alu_* outputs driven 0.
  - On req_valid&&req_ready, latch op/a/b/rd.
  - Legal op: go to EXEC, load cycle counter with LAT-1. LAT is 1 for ADD/SUB/AND/OR, MUL_LAT for MUL, DIV_LAT for DIV.
  - Illegal op: pulse err_op and done in the next cycle (stall high that one cycle), no writeback, back to IDLE.
- EXEC:
  - alu_ctrl/alu_a/alu_b driven from latches, constant for all EXEC cycles.
  - Counter decrements each cycle.
  - When counter==0: capture alu_res->res_lo and alu_r15->res_hi, go to WB_LO.
- WB_LO:
  - wb_en=1, wb_addr=rd, wb_data=res_lo.
  - MUL/DIV go to WB_HI.
  - Other ops: done=1 this cycle, go to IDLE.
- WB_HI:
  - wb_en=1, wb_addr=15, wb_data=res_hi, done=1, go to IDLE.
  - If rd==15, WB_LO writes res_lo to R15, then WB_HI overwrites it with res_hi; the final R15 value is res_hi.
- Latency, accept cycle = T:
  - ADD: EXEC T+1, WB_LO/done T+2; next accept T+3.
  - MUL (MUL_LAT=2): EXEC T+1..T+2, WB_LO T+3, WB_HI/done T+4.
- All outputs are registered except req_ready and stall, which decode the current state.
- Arithmetic is performed by the ALU only; the sequencer does no width conversion. Product = {res_hi,res_lo}.
- No second request is accepted while busy. req_valid held high is accepted in the cycle state returns to IDLE.

Optional Feature:
- Macro: ALU_SEQ_DIV0_TRAP_EN.
- Defined: DIV with latched b==0 skips EXEC and goes directly to WB_LO.
  - res_lo=16'hFFFF, res_hi=a.
  - err_div0 pulses in the WB_LO cycle; both writebacks still occur.
- Undefined: err_div0 port tied 0; DIV by zero runs through the ALU normally and its results are written unchanged.

Test Plan:
- ADD a=5, b=-3, rd=2 -> accept T, alu_ctrl=0 at T+1, wb_en at T+2 with addr 2, data 0x0002, done at T+2, req_ready back high at T+3.
- MUL a=300, b=300, rd=4, MUL_LAT=2 -> WB_LO at T+3: addr 4, data 0x5F90; WB_HI at T+4: addr 15, data 0x0001; stall high T+1..T+4.
- DIV a=-7, b=2, rd=1 -> writes addr 1 data 0xFFFD, then addr 15 data 0xFFFF; done only on the WB_HI cycle.
- req_op=9 -> err_op and done pulse at T+1, wb_en never asserted, ready at T+2.
- Reset asserted during MUL EXEC -> no wb_en afterwards, all outputs 0 and req_ready=1 after release.
- With ALU_SEQ_DIV0_TRAP_EN, DIV a=0x1234, b=0 -> err_div0 at T+1, wb 0xFFFF to rd then 0x1234 to R15.
